// File: rtl/clint_pkg.sv
// Shared CLINT bridge definitions: register window offsets, CLINT index encodings
// and bridge FSM state encodings.
package clint_pkg;

  localparam logic [15:0] MSIP_OFFSET     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFFSET = 16'h4000;
  localparam logic [15:0] MTIME_OFFSET    = 16'hBFF8;

  typedef enum logic [1:0] {
    IDX_MTIME    = 2'd0,
    IDX_MTIMECMP = 2'd1,
    IDX_MSIP     = 2'd2
  } clint_idx_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } bridge_state_e;

endpackage

// File: rtl/clint_addr_decode.sv
// Combinational decode of a CLINT byte offset into register index, upper-half
// select and an illegal-access flag.
module clint_addr_decode
  import clint_pkg::*;
(
  input  logic [15:0] addr,
  input  logic        size,
  output clint_idx_e  index,
  output logic        upper,
  output logic        illegal
);

  localparam logic [12:0] MSIP_WORD     = MSIP_OFFSET[15:3];
  localparam logic [12:0] MTIMECMP_WORD = MTIMECMP_OFFSET[15:3];
  localparam logic [12:0] MTIME_WORD    = MTIME_OFFSET[15:3];

  logic hit;

  always_comb begin
    index = IDX_MTIME;
    hit   = 1'b1;
    if (addr[15:3] == MSIP_WORD) begin
      index = IDX_MSIP;
    end else if (addr[15:3] == MTIMECMP_WORD) begin
      index = IDX_MTIMECMP;
    end else if (addr[15:3] == MTIME_WORD) begin
      index = IDX_MTIME;
    end else begin
      hit = 1'b0;
    end
  end

  assign upper   = addr[2];
  // Only 32-bit-aligned offsets exist; a 64-bit access must start on the low half.
  assign illegal = !hit || (addr[1:0] != 2'b00) || (size && addr[2]);

endmodule

// File: rtl/clint_bus_bridge.sv
// Bridges single-pulse core device-bus requests onto the CLINT register port.
// Define CLINT_BRIDGE_TIMEOUT_EN to abort reads that never see c_ready_i.
module clint_bus_bridge
  import clint_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            s_strobe_i,
  input  logic            s_rw_i,
  input  logic [15:0]     s_addr_i,
  input  logic            s_size_i,
  input  logic [XLEN-1:0] s_data_i,
  output logic            s_ready_o,
  output logic [XLEN-1:0] s_data_o,
  output logic            s_err_o,
  output logic            s_busy_o,
  output logic            c_en_o,
  output logic            c_we_o,
  output logic [1:0]      c_addr_o,
  output logic [XLEN-1:0] c_data_o,
  input  logic [XLEN-1:0] c_data_i,
  input  logic            c_ready_i
);

  localparam int HALF = XLEN / 2;

  if (XLEN != 64 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("clint_bus_bridge: XLEN must be 64 and TIMEOUT_CYCLES at least 1");
  end

  bridge_state_e   state_reg, state_next;
  logic            rw_reg, rw_next;
  logic            size_reg, size_next;
  logic [15:0]     addr_reg, addr_next;
  logic [HALF-1:0] wdata_reg, wdata_next;
  logic            ill_reg, ill_next;

  logic            ready_next, err_next, busy_next, en_next, we_next;
  logic [1:0]      caddr_next;
  logic [XLEN-1:0] sdata_next, cdata_next;

  logic            dec_upper, dec_illegal;
  clint_idx_e      dec_index;

  // The live request is decoded in IDLE; afterwards the captured one is.
  clint_addr_decode u_decode (
    .addr    ((state_reg == ST_IDLE) ? s_addr_i : addr_reg),
    .size    ((state_reg == ST_IDLE) ? s_size_i : size_reg),
    .index   (dec_index),
    .upper   (dec_upper),
    .illegal (dec_illegal)
  );

`ifdef CLINT_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wait_cnt_reg <= '0;
    else       wait_cnt_reg <= wait_cnt_next;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      rw_reg    <= 1'b0;
      size_reg  <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      ill_reg   <= 1'b0;
      s_ready_o <= 1'b0;
      s_data_o  <= '0;
      s_err_o   <= 1'b0;
      s_busy_o  <= 1'b0;
      c_en_o    <= 1'b0;
      c_we_o    <= 1'b0;
      c_addr_o  <= '0;
      c_data_o  <= '0;
    end else begin
      state_reg <= state_next;
      rw_reg    <= rw_next;
      size_reg  <= size_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      ill_reg   <= ill_next;
      s_ready_o <= ready_next;
      s_data_o  <= sdata_next;
      s_err_o   <= err_next;
      s_busy_o  <= busy_next;
      c_en_o    <= en_next;
      c_we_o    <= we_next;
      c_addr_o  <= caddr_next;
      c_data_o  <= cdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rw_next    = rw_reg;
    size_next  = size_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    ill_next   = ill_reg;
    ready_next = 1'b0;
    sdata_next = '0;
    err_next   = 1'b0;
    en_next    = 1'b0;
    we_next    = 1'b0;
    caddr_next = 2'd0;
    cdata_next = '0;
`ifdef CLINT_BRIDGE_TIMEOUT_EN
    wait_cnt_next = wait_cnt_reg;
`endif
    unique case (state_reg)
      ST_IDLE: begin
        if (s_strobe_i) begin
          rw_next    = s_rw_i;
          size_next  = s_size_i;
          addr_next  = s_addr_i;
          wdata_next = s_data_i[HALF-1:0];
          ill_next   = dec_illegal;
          if (dec_illegal) begin
            state_next = ST_RESP;
          end else if (s_rw_i && s_size_i) begin
            state_next = ST_WR_REQ;
            en_next    = 1'b1;
            we_next    = 1'b1;
            caddr_next = dec_index;
            cdata_next = s_data_i;
          end else begin
            state_next = ST_RD_REQ;
            en_next    = 1'b1;
            caddr_next = dec_index;
          end
        end
      end
      ST_RD_REQ: begin
        state_next = ST_RD_WAIT;
`ifdef CLINT_BRIDGE_TIMEOUT_EN
        wait_cnt_next = '0;
`endif
      end
      ST_RD_WAIT: begin
        if (c_ready_i) begin
          if (rw_reg) begin
            // Read-modify-write: only the addressed half takes the new data.
            state_next = ST_WR_REQ;
            en_next    = 1'b1;
            we_next    = 1'b1;
            caddr_next = dec_index;
            cdata_next = dec_upper ? {wdata_reg, c_data_i[HALF-1:0]}
                                   : {c_data_i[XLEN-1:HALF], wdata_reg};
          end else begin
            state_next = ST_RESP;
            ready_next = 1'b1;
            if (size_reg)       sdata_next = c_data_i;
            else if (dec_upper) sdata_next = {{HALF{1'b0}}, c_data_i[XLEN-1:HALF]};
            else                sdata_next = {{HALF{1'b0}}, c_data_i[HALF-1:0]};
          end
`ifdef CLINT_BRIDGE_TIMEOUT_EN
        end else if (wait_cnt_reg == CW'(TIMEOUT_CYCLES - 1)) begin
          state_next = ST_RESP;
          ready_next = 1'b1;
          err_next   = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
`endif
        end
      end
      ST_WR_REQ: begin
        state_next = ST_RESP;
        ready_next = 1'b1;
      end
      ST_RESP: begin
        // An illegal access enters RESP with no pulse yet and responds one cycle
        // later, so it lands at the same latency as a 64-bit write.
        if (s_ready_o) begin
          state_next = ST_IDLE;
        end else begin
          ready_next = 1'b1;
          err_next   = ill_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

endmodule

// File: doc/clint_bus_bridge.md
CLINT_BUS_BRIDGE -- requirements
Module: clint_bus_bridge

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the data width; only 64 is supported.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum cycles to wait for CLINT read data.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_strobe_i  input  1  one-cycle request pulse from the core device bus.
REQ-006 SHALL have port s_rw_i  input  1  1=write, 0=read.
REQ-007 SHALL have port s_addr_i  input  16  byte offset within the CLINT window.
REQ-008 SHALL have port s_size_i  input  1  1=64-bit access, 0=32-bit access.
REQ-009 SHALL have port s_data_i  input  XLEN  write data; 32-bit writes use bits [31:0].
REQ-010 SHALL have port s_ready_o  output  1  one-cycle response pulse.
REQ-011 SHALL have port s_data_o  output  XLEN  read data, valid with s_ready_o.
REQ-012 SHALL have port s_err_o  output  1  error flag, valid with s_ready_o.
REQ-013 SHALL have port s_busy_o  output  1  high in every state except IDLE.
REQ-014 SHALL have port c_en_o  output  1  CLINT enable.
REQ-015 SHALL have port c_we_o  output  1  CLINT write enable.
REQ-016 SHALL have port c_addr_o  output  2  CLINT index: 0=mtime, 1=mtimecmp, 2=msip.
REQ-017 SHALL have port c_data_o  output  XLEN  CLINT write data.
REQ-018 SHALL have port c_data_i  input  XLEN  CLINT read data.
REQ-019 SHALL have port c_ready_i  input  1  CLINT read-data-valid.

Function
REQ-020 SHALL decode the address as follows: 0x0000/0x0004 -> msip (index 2); 0x4000/0x4004 -> mtimecmp (index 1); 0xBFF8/0xBFFC -> mtime (index 0). An offset of +4 selects the upper 32-bit half.
REQ-021 SHALL flag as illegal any other offset, or any 64-bit access whose offset has bit 2 set.
REQ-022 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ and RESP; all outputs SHALL be registered.
REQ-023 SHALL, in IDLE on s_strobe_i, capture rw, addr, size and data, then go to RESP with error if the address is illegal, to WR_REQ for a 64-bit write, and to RD_REQ otherwise.
REQ-024 SHALL, in RD_REQ, drive c_en_o=1, c_we_o=0 and c_addr_o for exactly one cycle, then go to RD_WAIT.
REQ-025 SHALL, in RD_WAIT, latch c_data_i on c_ready_i, then go to RESP for a read or to WR_REQ for a 32-bit write.
REQ-026 SHALL, in WR_REQ, drive c_en_o=1, c_we_o=1 and c_data_o for exactly one cycle, then go to RESP.
REQ-027 SHALL build c_data_o for a 32-bit write by merging s_data_i[31:0] into the selected half of the latched read word; the other half keeps its latched value.
REQ-028 SHALL return 32-bit reads as the selected half zero-extended on s_data_o; 64-bit reads return the full word.
REQ-029 SHALL, in RESP, pulse s_ready_o for one cycle and return to IDLE; s_data_o SHALL be 0 for writes and errors.
REQ-030 SHALL ignore s_strobe_i in every state other than IDLE.
REQ-031 SHALL meet these latencies, measured from strobe at cycle T: 64-bit write or illegal access -> s_ready_o at T+2; read -> T+3 when c_ready_i arrives at T+2; 32-bit write -> T+4.
REQ-032 SHALL keep c_en_o and c_we_o low outside RD_REQ and WR_REQ.

Reset
REQ-033 SHALL, on rst_i assertion and at any time including mid-transaction, immediately force the state to IDLE and all outputs and captured registers to 0, with no CLINT access issued.

Configuration
REQ-034 SHALL, with CLINT_BRIDGE_TIMEOUT_EN defined, count cycles in RD_WAIT and, after TIMEOUT_CYCLES without c_ready_i, go to RESP with s_err_o=1 and s_data_o=0 and issue no write.
REQ-035 SHALL, without CLINT_BRIDGE_TIMEOUT_EN, remain in RD_WAIT indefinitely, and the counter SHALL be absent.

Structure
REQ-036 SHALL place the CLINT offsets (0x0000, 0x4000, 0xBFF8), the index encodings and the FSM state encodings in the shared package clint_pkg.
REQ-037 SHALL implement address decode as combinational sub-module clint_addr_decode, with outputs index, upper-half and illegal.

Verification
REQ-038 SHALL verify: 64-bit write 0x0000_0000_0000_0100 to 0x4000 -> one cycle with c_we_o=1, c_addr_o=1, c_data_o=0x100; s_ready_o at T+2, s_err_o=0.
REQ-039 SHALL verify: 32-bit write 0xDEAD_BEEF to 0x4004 while mtimecmp=0x0000_0000_1234_5678 -> read cycle then write of 0xDEAD_BEEF_1234_5678; s_ready_o at T+4.
REQ-040 SHALL verify: 32-bit read of 0xBFFC while mtime=0x0000_0001_0000_0005 -> s_data_o=0x0000_0000_0000_0001.
REQ-041 SHALL verify: read of 0x2000 -> s_err_o=1 and s_data_o=0 at T+2, with c_en_o never asserted.
REQ-042 SHALL verify: with the macro defined and c_ready_i tied low -> s_err_o=1 after 16 RD_WAIT cycles.
REQ-043 SHALL verify: rst_i asserted during RD_WAIT -> outputs 0 immediately and a strobe after reset is serviced normally.
